// File: rtl/ifetch_if.sv
// Fetch-stage bundle: run control, branch redirect, loader port and fetch results.
interface ifetch_if #(
    parameter int PC_SIZE  = 32,
    parameter int BUS_SIZE = 32
);
    logic                i_enable;
    logic                i_stall;
    logic                i_next_pc_src;
    logic [PC_SIZE-1:0]  i_next_not_seq_pc;
    logic                i_wr_enable;
    logic [BUS_SIZE-1:0] i_wr_data;
    logic                i_flush;
    logic [BUS_SIZE-1:0] o_instruction;
    logic [PC_SIZE-1:0]  o_pc;
    logic [PC_SIZE-1:0]  o_next_seq_pc;
    logic                o_halt;
    logic                o_mem_full;
    logic                o_mem_empty;

    // The pipeline/loader side drives the controls and observes the fetch results
    modport master (
        output i_enable, i_stall, i_next_pc_src, i_next_not_seq_pc,
               i_wr_enable, i_wr_data, i_flush,
        input  o_instruction, o_pc, o_next_seq_pc, o_halt, o_mem_full, o_mem_empty
    );

    // The fetch stage consumes the controls and produces the fetch results
    modport slave (
        input  i_enable, i_stall, i_next_pc_src, i_next_not_seq_pc,
               i_wr_enable, i_wr_data, i_flush,
        output o_instruction, o_pc, o_next_seq_pc, o_halt, o_mem_full, o_mem_empty
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, RUN/HALTED control, and a loadable
// instruction memory filled sequentially through a loader pointer.
module ifetch #(
    parameter int PC_SIZE           = 32,
    parameter int BUS_SIZE          = 32,
    parameter int MEM_SIZE_IN_WORDS = 64
) (
    input  logic   i_clk,
    input  logic   i_reset,
    ifetch_if.slave bus
);
    localparam int AW = $clog2(MEM_SIZE_IN_WORDS);
    localparam logic [BUS_SIZE-1:0] HALT_WORD = '1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [PC_SIZE-1:0]  pc_q, pc_d;
    logic [AW:0]         wrPtr_q, wrPtr_d;
    logic [BUS_SIZE-1:0] mem_q [MEM_SIZE_IN_WORDS];

    logic [AW-1:0]       wordIdx;
    logic                inRange;
    logic [BUS_SIZE-1:0] instrWord;
    logic [PC_SIZE-1:0]  seqPc;
    logic                advance;
    logic                isHalt;
    logic                memFull;
    logic                memEmpty;
    logic                wrAccept;

    // Addresses past the end of memory fetch HALT so a runaway PC stops the core
    assign wordIdx   = pc_q[AW+1:2];
    assign inRange   = pc_q < PC_SIZE'(4 * MEM_SIZE_IN_WORDS);
    assign instrWord = inRange ? mem_q[wordIdx] : HALT_WORD;
    assign seqPc     = pc_q + PC_SIZE'(4);
    assign advance   = bus.i_enable && !bus.i_stall;
    assign isHalt    = (instrWord == HALT_WORD);

    // The loader only writes while the core is not running, and never wraps
    assign memFull   = (wrPtr_q == (AW+1)'(MEM_SIZE_IN_WORDS));
    assign memEmpty  = (wrPtr_q == '0);
    assign wrAccept  = bus.i_wr_enable && !bus.i_enable && !memFull;

    // State and PC registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC: a HALT fetch freezes the PC at its own address
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                if (advance) begin
                    if (isHalt) begin
                        state_d = HALTED;
                    end else if (bus.i_next_pc_src) begin
                        pc_d = bus.i_next_not_seq_pc;
                    end else begin
                        pc_d = seqPc;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Fetch results presented to the pipeline and loader
    always_comb begin
        bus.o_halt        = (state_q == HALTED);
        bus.o_pc          = pc_q;
        bus.o_next_seq_pc = seqPc;
        bus.o_instruction = instrWord;
        bus.o_mem_full    = memFull;
        bus.o_mem_empty   = memEmpty;
    end

    // Loader pointer next value: flush wins over a simultaneous write
    always_comb begin
        wrPtr_d = wrPtr_q;
        if (bus.i_flush) begin
            wrPtr_d = '0;
        end else if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
    end

    // Loader pointer register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wrPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
        end
    end

    // Instruction memory: reset and flush clear every word in a single edge
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.i_flush) begin
            for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= bus.i_wr_data;
        end
    end
endmodule
